// File: rtl/arm_run_pkg.sv
// -----------------------------------------------------------------------------
// arm_run_pkg
//   Shared definitions for the ARM run-control sequencer:
//     - run_state_t        : 2-bit sequencer state (IDLE, RUN, PAUSE, DONE)
//     - HALT_INSTR_DEFAULT : "B ." branch-to-self, the end-of-program marker
//     - LED_*              : state encodings, so board top levels can decode
//                            the state output onto LEDs without the enum
//     - seq_next_pc()      : PC of the next instruction for sequential flow
// -----------------------------------------------------------------------------
package arm_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hEAFF_FFFE;

  localparam logic [1:0] LED_IDLE  = 2'd0;
  localparam logic [1:0] LED_RUN   = 2'd1;
  localparam logic [1:0] LED_PAUSE = 2'd2;
  localparam logic [1:0] LED_DONE  = 2'd3;

  // ARM instructions are word sized; sequential flow advances by 4 bytes.
  function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
//   One-cycle pulse on each rising edge of a level input (button request).
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-high reset
//     in     : level input
//     pulse  : high for one cycle when in rises (in & ~history)
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // The history register tracks the input level even while reset is held,
  // so a request held through reset does not fire on the release cycle.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q <= in;
    end else begin
      in_q <= in;
    end
  end

  assign pulse = in & ~in_q & ~reset;

endmodule

// File: rtl/arm_run_ctrl.sv
// -----------------------------------------------------------------------------
// arm_run_ctrl
//   Run-control sequencer for the single-cycle ARM core. Drives the core's
//   start enable (gates PC/state update) and provides run, single-step and
//   pause from board buttons. Stops the core on a PC breakpoint or on the
//   halt instruction, and counts executed instructions.
//
//   Parameters:
//     HALT_INSTR  : encoding that ends the program
//     CNT_W       : width of the executed-instruction counter
//   Ports:
//     clk, reset  : system clock, synchronous active-high reset
//     run_req     : run request (rising edge)
//     step_req    : single-step request (rising edge)
//     halt_req    : pause request (rising edge)
//     bp_en       : breakpoint enable (level)
//     bp_addr     : breakpoint PC (level)
//     PC, Instr   : current core PC and the instruction fetched there
//     start       : core enable; core executes Instr at PC when high
//     state       : registered state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//     halted_pc   : PC at which the core last stopped
//     instr_count : cycles with start=1, saturating
// -----------------------------------------------------------------------------
module arm_run_ctrl
  import arm_run_pkg::*;
#(
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      PC,
  input  logic [31:0]      Instr,
  output logic             start,
  output logic [1:0]       state,
  output logic [31:0]      halted_pc,
  output logic [CNT_W-1:0] instr_count
);

  // ---------------------------------------------------------------------------
  // Request edge detection
  // ---------------------------------------------------------------------------
  logic run_p;
  logic step_p;
  logic halt_p;

  rise_detect u_run_edge (
    .clk   (clk),
    .reset (reset),
    .in    (run_req),
    .pulse (run_p)
  );

  rise_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .in    (step_req),
    .pulse (step_p)
  );

  rise_detect u_halt_edge (
    .clk   (clk),
    .reset (reset),
    .in    (halt_req),
    .pulse (halt_p)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  run_state_t       state_q;
  run_state_t       state_d;
  logic             step_active_q;
  logic             step_active_d;
  logic             bp_skip_q;
  logic             bp_skip_d;
  logic [31:0]      halted_pc_q;
  logic [31:0]      halted_pc_d;
  logic [CNT_W-1:0] count_q;

  // ---------------------------------------------------------------------------
  // Stop detection and core enable
  // ---------------------------------------------------------------------------
  logic       halt_hit;
  logic       bp_hit;
  logic       stop_now;
  logic       exec_slot;
  logic       start_int;
  run_state_t stop_state;

  assign halt_hit = (Instr == HALT_INSTR);
  // bp_skip suppresses the trap for exactly the instruction we stopped on,
  // so resuming from a breakpoint executes it instead of re-trapping.
  assign bp_hit   = bp_en & (PC == bp_addr) & ~bp_skip_q;
  assign stop_now = halt_hit | bp_hit;

  // A halt instruction ends the program; a breakpoint only pauses it.
  assign stop_state = halt_hit ? DONE : PAUSE;

  // The core never executes the instruction that triggered a stop.
  assign exec_slot = (state_q == RUN) | step_active_q;
  assign start_int = exec_slot & ~stop_now;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    step_active_d = 1'b0;
    bp_skip_d     = bp_skip_q;
    halted_pc_d   = halted_pc_q;

    // The first executed instruction after a breakpoint re-arms it.
    if (start_int) begin
      bp_skip_d = 1'b0;
    end

    case (state_q)
      IDLE, PAUSE: begin
        if (step_active_q) begin
          // Step resolution: either stop on the target or run it once.
          if (stop_now) begin
            state_d     = stop_state;
            halted_pc_d = PC;
            bp_skip_d   = bp_hit;
          end else begin
            state_d     = PAUSE;
            halted_pc_d = seq_next_pc(PC);
          end
        end else if (step_p) begin
          // Step wins over a simultaneous run request.
          step_active_d = 1'b1;
        end else if (run_p) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop_now) begin
          state_d     = stop_state;
          halted_pc_d = PC;
          bp_skip_d   = bp_hit;
        end else if (halt_p) begin
          // The current instruction still executes this cycle, so the
          // resume point is the next sequential PC.
          state_d     = PAUSE;
          halted_pc_d = seq_next_pc(PC);
        end
      end

      DONE: begin
        // Sticky until reset.
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      step_active_q <= 1'b0;
      bp_skip_q     <= 1'b0;
      halted_pc_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      step_active_q <= step_active_d;
      bp_skip_q     <= bp_skip_d;
      halted_pc_q   <= halted_pc_d;
    end
  end

  // Executed-instruction counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (start_int && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start       = start_int;
  assign state       = state_q;
  assign halted_pc   = halted_pc_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_arm_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arm_run_ctrl
//   Directed, table-driven bench for arm_run_ctrl. Each table row is one
//   clock cycle: inputs are applied after a falling edge and outputs are
//   compared shortly after, before the next rising edge. Registered outputs
//   therefore show the effect of earlier rows; start reflects this row.
// -----------------------------------------------------------------------------
module tb_arm_run_ctrl;

  localparam logic [31:0] NOP  = 32'hE1A0_0000;
  localparam logic [31:0] HALT = 32'hEAFF_FFFE;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_req;
  logic        step_req;
  logic        halt_req;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        start;
  logic [1:0]  state;
  logic [31:0] halted_pc;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  arm_run_ctrl #(
    .HALT_INSTR (32'hEAFF_FFFE),
    .CNT_W      (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run_req     (run_req),
    .step_req    (step_req),
    .halt_req    (halt_req),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .PC          (PC),
    .Instr       (Instr),
    .start       (start),
    .state       (state),
    .halted_pc   (halted_pc),
    .instr_count (instr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        run;
    logic        step;
    logic        hlt;
    logic        bpe;
    logic [31:0] bpa;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        e_start;
    logic [1:0]  e_state;
    logic [31:0] e_hpc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic run, input logic step,
                     input logic hlt, input logic bpe, input logic [31:0] bpa,
                     input logic [31:0] pc, input logic [31:0] instr,
                     input logic e_start, input logic [1:0] e_state,
                     input logic [31:0] e_hpc, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.run = run; v.step = step; v.hlt = hlt;
    v.bpe = bpe; v.bpa = bpa; v.pc = pc; v.instr = instr;
    v.e_start = e_start; v.e_state = e_state;
    v.e_hpc = e_hpc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic run, input logic step,
                        input logic hlt, input logic bpe,
                        input logic [31:0] bpa, input logic [31:0] pc,
                        input logic [31:0] instr);
    @(negedge clk);
    reset    = rst;
    run_req  = run;
    step_req = step;
    halt_req = hlt;
    bp_en    = bpe;
    bp_addr  = bpa;
    PC       = pc;
    Instr    = instr;
    #2;
  endtask

  task automatic check_out(input string tag, input logic e_start,
                           input logic [1:0] e_state, input logic [31:0] e_hpc,
                           input logic [31:0] e_cnt);
    check({tag, "_start"}, {31'd0, start}, {31'd0, e_start});
    check({tag, "_state"}, {30'd0, state}, {30'd0, e_state});
    check({tag, "_halted_pc"}, halted_pc, e_hpc);
    check({tag, "_count"}, instr_count, e_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- Table A: reset, run 10+ instructions, halt instruction, DONE ----
    add(1, 0, 0, 0, 0, 0, 0, NOP,       0, S_IDLE, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, NOP,       0, S_IDLE, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, NOP,       0, S_IDLE, 0, 0);
    for (int i = 0; i <= 10; i++)
      add(0, (i == 0), 0, 0, 0, 0, 32'(4 * i), NOP, 1, S_RUN, 0, 32'(i));
    add(0, 0, 0, 0, 0, 0, 32'h1C, HALT, 0, S_RUN,  0,     11);
    add(0, 0, 0, 0, 0, 0, 32'h1C, HALT, 0, S_DONE, 32'h1C, 11);
    add(0, 1, 0, 0, 0, 0, 32'h20, NOP,  0, S_DONE, 32'h1C, 11);
    add(0, 0, 1, 0, 0, 0, 32'h20, NOP,  0, S_DONE, 32'h1C, 11);
    add(0, 0, 0, 1, 0, 0, 32'h20, NOP,  0, S_DONE, 32'h1C, 11);
    add(0, 0, 0, 0, 0, 0, 32'h20, NOP,  0, S_DONE, 32'h1C, 11);

    // ---- Table B: reset from DONE, breakpoint at 0x10 ----
    add(1, 0, 0, 0, 1, 32'h10, 0, NOP,  0, S_DONE, 32'h1C, 11);
    add(1, 0, 0, 0, 1, 32'h10, 0, NOP,  0, S_IDLE, 0, 0);
    add(0, 0, 0, 0, 1, 32'h10, 0, NOP,  0, S_IDLE, 0, 0);
    add(0, 1, 0, 0, 1, 32'h10, 0, NOP,  0, S_IDLE, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 1, 32'h10, 32'(4 * i), NOP, 1, S_RUN, 0, 32'(i));
    add(0, 0, 0, 0, 1, 32'h10, 32'h10, NOP, 0, S_RUN,   0,      4);
    add(0, 0, 0, 0, 1, 32'h10, 32'h10, NOP, 0, S_PAUSE, 32'h10, 4);
    // Resume: the breakpoint instruction executes once, then traps again.
    add(0, 1, 0, 0, 1, 32'h10, 32'h10, NOP, 0, S_PAUSE, 32'h10, 4);
    add(0, 1, 0, 0, 1, 32'h10, 32'h10, NOP, 1, S_RUN,   32'h10, 4);
    add(0, 0, 0, 0, 1, 32'h10, 32'h14, NOP, 1, S_RUN,   32'h10, 5);
    add(0, 0, 0, 0, 1, 32'h10, 32'h10, NOP, 0, S_RUN,   32'h10, 6);
    add(0, 0, 0, 0, 1, 32'h10, 32'h10, NOP, 0, S_PAUSE, 32'h10, 6);
    // Step with step_req held for 5 cycles: exactly one executed cycle.
    add(0, 0, 1, 0, 1, 32'h10, 32'h20, NOP, 0, S_PAUSE, 32'h10, 6);
    add(0, 0, 1, 0, 1, 32'h10, 32'h20, NOP, 1, S_PAUSE, 32'h10, 6);
    add(0, 0, 1, 0, 1, 32'h10, 32'h20, NOP, 0, S_PAUSE, 32'h24, 7);
    add(0, 0, 1, 0, 1, 32'h10, 32'h20, NOP, 0, S_PAUSE, 32'h24, 7);
    add(0, 0, 1, 0, 1, 32'h10, 32'h20, NOP, 0, S_PAUSE, 32'h24, 7);
    add(0, 0, 0, 0, 1, 32'h10, 32'h20, NOP, 0, S_PAUSE, 32'h24, 7);
    // halt_req while running: current instruction executes, resume at PC+4.
    add(0, 1, 0, 0, 0, 32'h10, 32'h00, NOP, 0, S_PAUSE, 32'h24, 7);
    add(0, 0, 0, 0, 0, 32'h10, 32'h04, NOP, 1, S_RUN,   32'h24, 7);
    add(0, 0, 0, 1, 0, 32'h10, 32'h08, NOP, 1, S_RUN,   32'h24, 8);
    add(0, 0, 0, 0, 0, 32'h10, 32'h0C, NOP, 0, S_PAUSE, 32'h0C, 9);
    // run and step rise together from PAUSE: step wins, single start cycle.
    add(0, 1, 1, 0, 0, 32'h10, 32'h0C, NOP, 0, S_PAUSE, 32'h0C, 9);
    add(0, 1, 1, 0, 0, 32'h10, 32'h0C, NOP, 1, S_PAUSE, 32'h0C, 9);
    add(0, 1, 1, 0, 0, 32'h10, 32'h10, NOP, 0, S_PAUSE, 32'h10, 10);
    add(0, 0, 0, 0, 0, 32'h10, 32'h10, NOP, 0, S_PAUSE, 32'h10, 10);

    // Initial reset so the first table row sees defined registers.
    set_in(1, 0, 0, 0, 0, 0, 0, NOP);
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      set_in(vecs[i].rst, vecs[i].run, vecs[i].step, vecs[i].hlt,
             vecs[i].bpe, vecs[i].bpa, vecs[i].pc, vecs[i].instr);
      check_out($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_state,
                vecs[i].e_hpc, vecs[i].e_cnt);
    end

    // ---- Step onto a halt instruction from PAUSE: no execution, DONE ----
    set_in(0, 0, 1, 0, 0, 0, 32'h40, HALT);
    check_out("stephalt_req", 0, S_PAUSE, 32'h10, 10);
    set_in(0, 0, 1, 0, 0, 0, 32'h40, HALT);
    check_out("stephalt_resolve", 0, S_PAUSE, 32'h10, 10);
    set_in(0, 0, 0, 0, 0, 0, 32'h40, NOP);
    check_out("stephalt_done", 0, S_DONE, 32'h40, 10);
    set_in(0, 1, 0, 0, 0, 0, 32'h40, NOP);
    check_out("stephalt_sticky", 0, S_DONE, 32'h40, 10);

    // ---- Reset mid-run with run_req held high ----
    set_in(1, 0, 0, 0, 0, 0, 0, NOP);
    set_in(0, 0, 0, 0, 0, 0, 0, NOP);
    check_out("midrst_idle", 0, S_IDLE, 0, 0);
    set_in(0, 1, 0, 0, 0, 0, 0, NOP);
    check_out("midrst_req", 0, S_IDLE, 0, 0);
    set_in(0, 1, 0, 0, 0, 0, 0, NOP);
    check_out("midrst_run0", 1, S_RUN, 0, 0);
    set_in(0, 1, 0, 0, 0, 0, 32'h04, NOP);
    check_out("midrst_run1", 1, S_RUN, 0, 1);
    set_in(1, 1, 0, 0, 0, 0, 32'h08, NOP);
    check_out("midrst_rstcyc", 1, S_RUN, 0, 2);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, NOP);
      check_out($sformatf("midrst_held%0d", i), 0, S_IDLE, 0, 0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, NOP);
    check_out("midrst_low", 0, S_IDLE, 0, 0);
    set_in(0, 1, 0, 0, 0, 0, 0, NOP);
    check_out("midrst_rise", 0, S_IDLE, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, NOP);
    check_out("midrst_rerun", 1, S_RUN, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
